// File: rtl/psg_stereo_mixer.sv
// Stereo PSG/beeper mixer: time-multiplexed per-channel panning into left/right
// accumulators, saturated sample latch, and one first-order sigma-delta DAC per side.
module psg_stereo_mixer #(
    parameter int         NCH        = 4,
    parameter int         IW         = 8,
    parameter int         SAMPLE_DIV = 64,
    parameter int         BEEP_LVL   = 64,
    parameter logic [7:0] REG_PAN    = 8'h40,
    parameter logic [7:0] REG_CTRL   = 8'h41
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH*IW-1:0]   ch_in,
    input  logic                spk,
    input  logic                mic,
    input  logic                ear,
    input  logic [7:0]          addr,
    input  logic                ior,
    input  logic                iow,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic                oe_n,
    output logic [IW+1:0]       sample_l,
    output logic [IW+1:0]       sample_r,
    output logic                sample_stb,
    output logic                audio_l,
    output logic                audio_r
);
    localparam int OW   = IW + 2;
    localparam int AW   = OW + 1;
    localparam int CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [AW-1:0]   LVL_SPK  = AW'(BEEP_LVL);
    localparam logic [AW-1:0]   LVL_LOW  = AW'(BEEP_LVL >> 2);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ACC, BEEP, LATCH} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      pan_reg, ctrl_reg;
    logic [7:0]      snap_pan_reg, snap_pan_next;
    logic [7:0]      snap_ctrl_reg, snap_ctrl_next;
    logic [CW-1:0]   cnt_reg;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [AW-1:0]   acc_l_reg, acc_l_next, acc_r_reg, acc_r_next;
    logic [OW-1:0]   sample_l_reg, sample_l_next, sample_r_reg, sample_r_next;
    logic            stb_reg, stb_next;
    logic [AW-1:0]   integ_reg [2];
    logic [OW-1:0]   dac_in [2];

    logic [IW-1:0]   ch_arr [NCH];
    logic [IW-1:0]   cur_ch;
    logic            cur_pl, cur_pr;
    logic [AW-1:0]   beep_add;
    logic            frame_stb, sel_pan, sel_ctrl;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_arr[gi] = ch_in[gi*IW +: IW];
        end
    endgenerate

    function automatic logic [OW-1:0] sat(input logic [AW-1:0] a);
        return a[OW] ? {OW{1'b1}} : a[OW-1:0];
    endfunction

    // Register file access
    assign sel_pan  = (addr == REG_PAN);
    assign sel_ctrl = (addr == REG_CTRL);
    assign oe_n     = !(ior && (sel_pan || sel_ctrl));

    always_comb begin
        dout = 8'h00;
        if (ior && sel_pan)
            dout = pan_reg;
        else if (ior && sel_ctrl)
            dout = ctrl_reg;
    end

    assign frame_stb = (cnt_reg == CNT_LAST);

    // Channel currently being accumulated and its snapshot pan bits
    always_comb begin
        cur_ch = '0;
        cur_pl = 1'b0;
        cur_pr = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_reg == IDXW'(i)) begin
                cur_ch = ch_arr[i];
                cur_pl = snap_pan_reg[2*i];
                cur_pr = snap_pan_reg[2*i+1];
            end
        end
    end

    always_comb begin
        beep_add = '0;
        if (!snap_ctrl_reg[0])
            beep_add = (spk ? LVL_SPK : '0) + (mic ? LVL_LOW : '0);
        if (snap_ctrl_reg[1] && ear)
            beep_add = beep_add + LVL_LOW;
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        acc_l_next     = acc_l_reg;
        acc_r_next     = acc_r_reg;
        snap_pan_next  = snap_pan_reg;
        snap_ctrl_next = snap_ctrl_reg;
        sample_l_next  = sample_l_reg;
        sample_r_next  = sample_r_reg;
        stb_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_stb) begin
                    snap_pan_next  = pan_reg;
                    snap_ctrl_next = ctrl_reg;
                    acc_l_next     = '0;
                    acc_r_next     = '0;
                    idx_next       = '0;
                    state_next     = ACC;
                end
            end
            ACC: begin
                if (cur_pl) acc_l_next = acc_l_reg + AW'(cur_ch);
                if (cur_pr) acc_r_next = acc_r_reg + AW'(cur_ch);
                if (idx_reg == IDX_LAST)
                    state_next = BEEP;
                else
                    idx_next = idx_reg + 1'b1;
            end
            BEEP: begin
                acc_l_next = acc_l_reg + beep_add;
                acc_r_next = acc_r_reg + beep_add;
                state_next = LATCH;
            end
            LATCH: begin
                sample_l_next = sat(acc_l_reg);
                sample_r_next = sat(acc_r_reg);
                stb_next      = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pan_reg       <= 8'hFF;
            ctrl_reg      <= 8'h00;
            snap_pan_reg  <= 8'hFF;
            snap_ctrl_reg <= 8'h00;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
            idx_reg       <= '0;
            acc_l_reg     <= '0;
            acc_r_reg     <= '0;
            sample_l_reg  <= '0;
            sample_r_reg  <= '0;
            stb_reg       <= 1'b0;
        end else begin
            if (iow && sel_pan)  pan_reg  <= din;
            if (iow && sel_ctrl) ctrl_reg <= din;
            cnt_reg       <= frame_stb ? '0 : cnt_reg + 1'b1;
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            acc_l_reg     <= acc_l_next;
            acc_r_reg     <= acc_r_next;
            snap_pan_reg  <= snap_pan_next;
            snap_ctrl_reg <= snap_ctrl_next;
            sample_l_reg  <= sample_l_next;
            sample_r_reg  <= sample_r_next;
            stb_reg       <= stb_next;
        end
    end

    // Sigma-delta: the carry out of the OW-bit integrator is the output bit
    assign dac_in[0] = sample_l_reg;
    assign dac_in[1] = sample_r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++)
                integ_reg[s] <= '0;
        end else begin
            for (int s = 0; s < 2; s++)
                integ_reg[s] <= {1'b0, integ_reg[s][OW-1:0]} + {1'b0, dac_in[s]};
        end
    end

    assign sample_l   = sample_l_reg;
    assign sample_r   = sample_r_reg;
    assign sample_stb = stb_reg;
    assign audio_l    = integ_reg[0][OW];
    assign audio_r    = integ_reg[1][OW];

endmodule
